// File: rtl/video_counters.sv
// 640x480@60 VGA raster timing: free-running pixel/line counters with
// flop-driven sync and display-enable outputs decoded one step ahead.
`timescale 1ns/1ps
module video_counters #(
   parameter int H_VISIBLE = 640,
   parameter int H_FRONT   = 16,
   parameter int H_SYNC    = 96,
   parameter int H_BACK    = 48,
   parameter int V_VISIBLE = 480,
   parameter int V_FRONT   = 10,
   parameter int V_SYNC    = 2,
   parameter int V_BACK    = 33
) (
   input  logic       clk,
   input  logic       rst_n,
   output logic       vsync,
   output logic       hsync,
   output logic       video_on,
   output logic [9:0] hpos,
   output logic [8:0] vpos
);
   localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
   localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

   logic [9:0] r_hc, r_vc;
   logic       r_hsync, r_vsync, r_video_on;
   logic [9:0] w_hc_nxt, w_vc_nxt;
   logic       w_hwrap;
   logic       w_hsync_nxt, w_vsync_nxt, w_video_on_nxt;

   always_comb begin
      w_hwrap  = (r_hc == 10'(H_TOTAL - 1));
      w_hc_nxt = w_hwrap ? 10'd0 : r_hc + 10'd1;
      w_vc_nxt = r_vc;
      if (w_hwrap)
         w_vc_nxt = (r_vc == 10'(V_TOTAL - 1)) ? 10'd0 : r_vc + 10'd1;
   end

   // Decoding the next counter value lets the flops line up with hpos/vpos
   // in the same cycle while still being glitch-free registered outputs.
   always_comb begin
      w_hsync_nxt    = !((w_hc_nxt >= 10'(H_VISIBLE + H_FRONT)) &&
                         (w_hc_nxt <  10'(H_VISIBLE + H_FRONT + H_SYNC)));
      w_vsync_nxt    = !((w_vc_nxt >= 10'(V_VISIBLE + V_FRONT)) &&
                         (w_vc_nxt <  10'(V_VISIBLE + V_FRONT + V_SYNC)));
      w_video_on_nxt = (w_hc_nxt < 10'(H_VISIBLE)) && (w_vc_nxt < 10'(V_VISIBLE));
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_hc       <= 10'd0;
         r_vc       <= 10'd0;
         r_hsync    <= 1'b1;
         r_vsync    <= 1'b1;
         r_video_on <= 1'b1;
      end else begin
         r_hc       <= w_hc_nxt;
         r_vc       <= w_vc_nxt;
         r_hsync    <= w_hsync_nxt;
         r_vsync    <= w_vsync_nxt;
         r_video_on <= w_video_on_nxt;
      end
   end

   assign hpos     = r_hc;
   // Lines past 510 are clamped so vpos stays monotonic within the frame.
   assign vpos     = (r_vc < 10'd511) ? r_vc[8:0] : 9'd511;
   assign hsync    = r_hsync;
   assign vsync    = r_vsync;
   assign video_on = r_video_on;
endmodule

// File: tb/tb_video_counters.sv
// Bench for video_counters: a full-size instance for line-level vectors and a
// narrow-line instance (16 clocks/line, full 525 lines) for whole-frame checks.
`timescale 1ns/1ps
module tb_video_counters;
   logic clk = 1'b0;
   logic rst_a, rst_b;
   logic hs_a, vs_a, von_a, hs_b, vs_b, von_b;
   logic [9:0] hp_a, hp_b;
   logic [8:0] vp_a, vp_b;

   int n_chk = 0;
   int n_fail = 0;
   int ta, tb;
   localparam int FB = 525 * 16;
   localparam logic [21:0] RST_VAL = {1'b1, 1'b1, 1'b1, 10'd0, 9'd0};

   always #5 clk = ~clk;

   video_counters u_a (
      .clk(clk), .rst_n(rst_a), .vsync(vs_a), .hsync(hs_a),
      .video_on(von_a), .hpos(hp_a), .vpos(vp_a));

   video_counters #(.H_VISIBLE(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(3)) u_b (
      .clk(clk), .rst_n(rst_b), .vsync(vs_b), .hsync(hs_b),
      .video_on(von_b), .hpos(hp_b), .vpos(vp_b));

   // Reference: position is purely the number of clocks since reset release.
   function automatic logic [21:0] model(int t, int hv, int hf, int hsw, int hb,
                                         int vv, int vf, int vsw, int vb);
      int ht, vt, hc, vc, vp;
      logic hsn, vsn, von;
      ht  = hv + hf + hsw + hb;
      vt  = vv + vf + vsw + vb;
      hc  = t % ht;
      vc  = (t / ht) % vt;
      vp  = (vc < 511) ? vc : 511;
      hsn = !(hc >= hv + hf && hc < hv + hf + hsw);
      vsn = !(vc >= vv + vf && vc < vv + vf + vsw);
      von = (hc < hv) && (vc < vv);
      return {hsn, vsn, von, 10'(hc), 9'(vp)};
   endfunction

   task automatic check(input string name, input logic [21:0] act, input logic [21:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s @%0t: got %h want %h", name, $time, act, exp);
      end
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_chk++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d want %0d", name, act, exp);
      end
   endtask

   always @(posedge clk or negedge rst_a) if (!rst_a) ta <= 0; else ta <= ta + 1;
   always @(posedge clk or negedge rst_b) if (!rst_b) tb <= 0; else tb <= tb + 1;

   // Per-cycle comparison against the model plus event accounting.
   int   hs_low0 = 0, von_hi0 = 0;
   bit   line0_done = 0;
   int   von_rise = 0, von_hi = 0, hs_fall = 0, vs_fall = 0, vs_low = 0, sat = 0;
   logic p_von = 1'b1, p_hs = 1'b1, p_vs = 1'b1;
   always @(negedge clk) begin
      check("trace_a", {hs_a, vs_a, von_a, hp_a, vp_a},
            model(ta, 640, 16, 96, 48, 480, 10, 2, 33));
      check("trace_b", {hs_b, vs_b, von_b, hp_b, vp_b},
            model(tb, 8, 2, 3, 3, 480, 10, 2, 33));
      if (!line0_done && ta >= 1 && ta <= 800) begin
         if (!hs_a) hs_low0++;
         if (von_a) von_hi0++;
         if (ta == 800) line0_done = 1;
      end
      if (tb >= FB && tb < 2 * FB) begin
         if (von_b && !p_von) von_rise++;
         if (von_b) von_hi++;
         if (!hs_b && p_hs) hs_fall++;
         if (!vs_b && p_vs) vs_fall++;
         if (!vs_b) vs_low++;
         if (vp_b == 9'd511) sat++;
      end
      p_von = von_b; p_hs = hs_b; p_vs = vs_b;
   end

   // Registered outputs may only move on a clock edge or a reset assertion.
   time t_pos = 0, t_ra = 0, t_rb = 0;
   always @(posedge clk) t_pos = $time;
   always @(negedge rst_a) t_ra = $time;
   always @(negedge rst_b) t_rb = $time;
   always @(hs_a or vs_a or von_a) if ($time > 0) begin
      n_chk++;
      if ($time != t_pos && $time != t_ra) begin
         n_fail++;
         $display("FAIL glitch_a: change at %0t, last edge %0t", $time, t_pos);
      end
   end
   always @(hs_b or vs_b or von_b) if ($time > 0) begin
      n_chk++;
      if ($time != t_pos && $time != t_rb) begin
         n_fail++;
         $display("FAIL glitch_b: change at %0t, last edge %0t", $time, t_pos);
      end
   end

   typedef struct {
      int         t;
      logic [9:0] hp;
      logic [8:0] vp;
      logic       hs, vs, von;
   } vec_t;
   vec_t vecs[14];

   initial begin
      vecs[0]  = '{0,    10'd0,   9'd0, 1'b1, 1'b1, 1'b1};
      vecs[1]  = '{1,    10'd1,   9'd0, 1'b1, 1'b1, 1'b1};
      vecs[2]  = '{2,    10'd2,   9'd0, 1'b1, 1'b1, 1'b1};
      vecs[3]  = '{639,  10'd639, 9'd0, 1'b1, 1'b1, 1'b1};
      vecs[4]  = '{640,  10'd640, 9'd0, 1'b1, 1'b1, 1'b0};
      vecs[5]  = '{655,  10'd655, 9'd0, 1'b1, 1'b1, 1'b0};
      vecs[6]  = '{656,  10'd656, 9'd0, 1'b0, 1'b1, 1'b0};
      vecs[7]  = '{751,  10'd751, 9'd0, 1'b0, 1'b1, 1'b0};
      vecs[8]  = '{752,  10'd752, 9'd0, 1'b1, 1'b1, 1'b0};
      vecs[9]  = '{799,  10'd799, 9'd0, 1'b1, 1'b1, 1'b0};
      vecs[10] = '{800,  10'd0,   9'd1, 1'b1, 1'b1, 1'b1};
      vecs[11] = '{1439, 10'd639, 9'd1, 1'b1, 1'b1, 1'b1};
      vecs[12] = '{1440, 10'd640, 9'd1, 1'b1, 1'b1, 1'b0};
      vecs[13] = '{1600, 10'd0,   9'd2, 1'b1, 1'b1, 1'b1};

      rst_a = 1'b0;
      rst_b = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_a", {hs_a, vs_a, von_a, hp_a, vp_a}, RST_VAL);
      check("reset_b", {hs_b, vs_b, von_b, hp_b, vp_b}, RST_VAL);
      rst_a = 1'b1;
      rst_b = 1'b1;

      foreach (vecs[i]) begin
         while (ta < vecs[i].t) @(negedge clk);
         check($sformatf("vec%0d_t%0d", i, vecs[i].t), {hs_a, vs_a, von_a, hp_a, vp_a},
               {vecs[i].hs, vecs[i].vs, vecs[i].von, vecs[i].hp, vecs[i].vp});
      end
      check_int("line0_hsync_low", hs_low0, 96);
      check_int("line0_video_on_high", von_hi0, 640);

      while (tb < 2 * FB + 2) @(negedge clk);
      check_int("frame_von_rises", von_rise, 480);
      check_int("frame_von_high", von_hi, 480 * 8);
      check_int("frame_hsync_falls", hs_fall, 525);
      check_int("frame_vsync_falls", vs_fall, 1);
      check_int("frame_vsync_low", vs_low, 2 * 16);
      check_int("frame_vpos_sat", sat, (525 - 511) * 16);

      // Mid-frame async reset at line 300, hpos 10 (inside hsync, blanked).
      while (tb < 2 * FB + 300 * 16 + 10) @(negedge clk);
      check("pre_midreset_b", {hs_b, vs_b, von_b, hp_b, vp_b},
            {1'b0, 1'b1, 1'b0, 10'd10, 9'd300});
      #2 rst_b = 1'b0;
      #1 check("midreset_b", {hs_b, vs_b, von_b, hp_b, vp_b}, RST_VAL);
      repeat (2) @(negedge clk);
      rst_b = 1'b1;
      repeat (20) @(negedge clk);

      for (int k = 0; k < 6; k++) begin
         repeat ($urandom_range(1, 2000)) @(negedge clk);
         @(posedge clk);
         #($urandom_range(1, 4));
         rst_a = 1'b0;
         rst_b = 1'b0;
         #0.5;
         check("rand_reset_a", {hs_a, vs_a, von_a, hp_a, vp_a}, RST_VAL);
         check("rand_reset_b", {hs_b, vs_b, von_b, hp_b, vp_b}, RST_VAL);
         repeat ($urandom_range(1, 3)) @(negedge clk);
         rst_a = 1'b1;
         rst_b = 1'b1;
      end
      repeat (900) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
